lsu_axi_write_responder: RTL and testbench



---
 rtl/lsu_axi_write_responder.sv | 159 +++++++++++++++
 tb/tb_lsu_axi_write_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_write_responder.sv
// AXI4 write slave terminating the LSU write master: commits byte-strobed beats into
// the GPIO/LA register bank and returns a B response tagged with the accepted ID.
module lsu_axi_write_responder #(
  parameter int          ID_W      = 3,
  parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [ID_W-1:0] bid,
  output logic [27:0]     gpio_out,
  output logic [27:0]     gpio_oeb,
  output logic [63:0]     la_out,
  output logic            wr_pulse
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t          state, state_nxt;
  logic            awready_q;
  logic [ID_W-1:0] id_q;
  logic [11:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [1:0]      err_q;
  logic            discard_q;

  logic            aw_hs, w_hs, final_beat, beat_ok;
  logic            aw_decerr, aw_slverr;
  logic [1:0]      beat_err;
  logic [31:0]     gpio_data_m, gpio_oeb_m, la_lo_m, la_hi_m;

  // Response codes are ordered by severity, so the numerically larger one wins.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign aw_hs      = awvalid && awready_q;
  assign w_hs       = wvalid && (state == S_DATA);
  assign final_beat = (cnt_q == len_q);
  assign aw_decerr  = (awaddr[31:12] != BASE_ADDR[31:12]);
  assign aw_slverr  = awsize[2] || awburst[1];
  assign beat_err   = ((addr_q[11:4] != 8'd0) || (wlast != final_beat)) ? RESP_SLVERR : RESP_OKAY;
  assign beat_ok    = !discard_q && (beat_err == RESP_OKAY);

  assign gpio_data_m = merge32({4'd0, gpio_out}, wdata[31:0],  wstrb[3:0]);
  assign gpio_oeb_m  = merge32({4'd0, gpio_oeb}, wdata[63:32], wstrb[7:4]);
  assign la_lo_m     = merge32(la_out[31:0],     wdata[31:0],  wstrb[3:0]);
  assign la_hi_m     = merge32(la_out[63:32],    wdata[63:32], wstrb[7:4]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (aw_hs)               state_nxt = S_DATA;
      S_DATA:  if (w_hs && final_beat)  state_nxt = S_RESP;
      S_RESP:  if (bready)              state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wready = (state == S_DATA);
    bvalid = (state == S_RESP);
  end

  // awready is its own flop so it stays low through reset while the FSM already sits in IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) awready_q <= 1'b0;
    else          awready_q <= (state_nxt == S_IDLE);
  end

  assign awready = awready_q;
  assign bresp   = err_q;
  assign bid     = id_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q     <= RESP_OKAY;
      id_q      <= '0;
      discard_q <= 1'b0;
    end else if (aw_hs) begin
      id_q      <= awid;
      discard_q <= aw_decerr || aw_slverr;
      err_q     <= aw_decerr ? RESP_DECERR : (aw_slverr ? RESP_SLVERR : RESP_OKAY);
    end else if (w_hs) begin
      err_q     <= worst(err_q, beat_err);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (aw_hs) begin
      addr_q  <= awaddr[11:0];
      len_q   <= awlen;
      size_q  <= awsize;
      burst_q <= awburst;
      cnt_q   <= 8'd0;
    end else if (w_hs) begin
      cnt_q <= cnt_q + 8'd1;
      if (burst_q == BURST_INCR) addr_q <= addr_q + (12'd1 << size_q);
    end
  end

  // Offset bit 3 selects the GPIO pair (0x00/0x04) or the LA pair (0x08/0x0C).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gpio_out <= '0;
      gpio_oeb <= '1;
      la_out   <= '0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (w_hs && beat_ok && (wstrb != 8'd0)) begin
        wr_pulse <= 1'b1;
        if (!addr_q[3]) begin
          gpio_out <= gpio_data_m[27:0];
          gpio_oeb <= gpio_oeb_m[27:0];
        end else begin
          la_out <= {la_hi_m, la_lo_m};
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_write_responder.sv
// Bench for lsu_axi_write_responder: expected B responses queued at AW time and popped
// at each B handshake; register side effects checked inline per scenario.
module tb_lsu_axi_write_responder;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        awvalid, awready;
  logic [2:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [2:0]  bid;
  logic [27:0] gpio_out, gpio_oeb;
  logic [63:0] la_out;
  logic        wr_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [2:0] id; logic [1:0] resp; } exp_t;
  exp_t sb[$];

  lsu_axi_write_responder #(.ID_W(3), .BASE_ADDR(32'hD000_0000)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .la_out(la_out), .wr_pulse(wr_pulse)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    bit done = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    sb.push_back('{id: id, resp: resp});
    for (int i = 0; i < 20 && !done; i++) begin
      if (awready) done = 1;
      step();
    end
    awvalid = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL aw_handshake got=timeout exp=accepted"); end
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit done = 0;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (wready) done = 1;
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL w_handshake got=timeout exp=accepted"); end
  endtask

  task automatic check_b();
    bit   done = 0;
    exp_t e;
    bready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bvalid) begin
        done = 1;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b_unexpected got=bid%0d/%b exp=none", bid, bresp);
        end else begin
          e = sb.pop_front();
          total++;
          if (bid !== e.id)     begin bad++; $display("FAIL bid got=%0d exp=%0d", bid, e.id); end
          if (bresp !== e.resp) begin bad++; $display("FAIL bresp got=%b exp=%b", bresp, e.resp); end
        end
      end
      step();
    end
    bready = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL b_timeout got=no_bvalid exp=bvalid"); end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    step(); step(); step();
    total++;
    if ({awready, wready, bvalid, wr_pulse} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {awready, wready, bvalid, wr_pulse});
    end
    total++;
    if ({bresp, bid} !== 5'd0) begin bad++; $display("FAIL reset_b got=%b exp=0", {bresp, bid}); end
    total++;
    if (gpio_out !== 28'h0 || gpio_oeb !== 28'hFFF_FFFF || la_out !== 64'h0) begin
      bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0/fffffff/0", gpio_out, gpio_oeb, la_out);
    end
    wb_rst_i = 1'b0;
    step();
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL idle_awready got=%b exp=1", awready); end
  endtask

  task automatic test_single();
    send_aw(3'd5, 32'hD000_0000, 8'd0, 3'd3, 2'b01, 2'b00);
    send_w(64'h0000_0000_0ABC_DEF0, 8'h0F, 1'b1);
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL single_bvalid_t2 got=%b exp=1", bvalid); end
    total++;
    if (gpio_out !== 28'hABC_DEF0 || gpio_oeb !== 28'hFFF_FFFF || wr_pulse !== 1'b1) begin
      bad++; $display("FAIL single_regs got=%h/%h/%b exp=abcdef0/fffffff/1", gpio_out, gpio_oeb, wr_pulse);
    end
    check_b();
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL single_awready_t3 got=%b exp=1", awready); end
  endtask

  task automatic test_strobes();
    send_aw(3'd1, 32'hD000_0008, 8'd0, 3'd3, 2'b01, 2'b00);
    send_w(64'h1122_3344_5566_7788, 8'h81, 1'b1);
    total++;
    if (la_out !== 64'h1100_0000_0000_0088) begin
      bad++; $display("FAIL strobe_la got=%h exp=1100000000000088", la_out);
    end
    check_b();
  endtask

  task automatic test_burst();
    send_aw(3'd6, 32'hD000_0000, 8'd1, 3'd3, 2'b01, 2'b00);
    send_w(64'h0000_0000_0000_0001, 8'hFF, 1'b0);
    total++;
    if (gpio_out !== 28'h1 || gpio_oeb !== 28'h0 || wr_pulse !== 1'b1 || bvalid !== 1'b0) begin
      bad++; $display("FAIL burst_beat0 got=%h/%h/%b/%b exp=1/0/1/0", gpio_out, gpio_oeb, wr_pulse, bvalid);
    end
    send_w(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1);
    total++;
    if (la_out !== 64'hDEAD_BEEF_CAFE_F00D || wr_pulse !== 1'b1) begin
      bad++; $display("FAIL burst_beat1 got=%h/%b exp=deadbeefcafef00d/1", la_out, wr_pulse);
    end
    check_b();
  endtask

  task automatic test_errors();
    send_aw(3'd1, 32'hC000_0000, 8'd0, 3'd3, 2'b01, 2'b11);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    total++;
    if (gpio_out !== 28'h1 || gpio_oeb !== 28'h0 || wr_pulse !== 1'b0) begin
      bad++; $display("FAIL decerr_regs got=%h/%h/%b exp=1/0/0", gpio_out, gpio_oeb, wr_pulse);
    end
    check_b();
    send_aw(3'd2, 32'hD000_0010, 8'd0, 3'd3, 2'b01, 2'b10);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    total++;
    if (la_out !== 64'hDEAD_BEEF_CAFE_F00D || wr_pulse !== 1'b0) begin
      bad++; $display("FAIL slverr_regs got=%h/%b exp=deadbeefcafef00d/0", la_out, wr_pulse);
    end
    check_b();
    send_aw(3'd3, 32'hD000_0008, 8'd1, 3'd3, 2'b00, 2'b10);
    send_w(64'h1111_1111_1111_1111, 8'hFF, 1'b1);
    total++;
    if (bvalid !== 1'b0 || wready !== 1'b1 || la_out !== 64'hDEAD_BEEF_CAFE_F00D || wr_pulse !== 1'b0) begin
      bad++; $display("FAIL early_wlast got=%b/%b/%h/%b exp=0/1/deadbeefcafef00d/0", bvalid, wready, la_out, wr_pulse);
    end
    send_w(64'h2222_2222_2222_2222, 8'hFF, 1'b1);
    total++;
    if (la_out !== 64'h2222_2222_2222_2222 || wr_pulse !== 1'b1 || bvalid !== 1'b1) begin
      bad++; $display("FAIL after_wlast got=%h/%b/%b exp=2222222222222222/1/1", la_out, wr_pulse, bvalid);
    end
    check_b();
  endtask

  task automatic test_backpressure();
    send_aw(3'd2, 32'hD000_0000, 8'd0, 3'd3, 2'b01, 2'b00);
    send_w(64'h0000_0123_0000_0000, 8'hF0, 1'b1);
    total++;
    if (gpio_oeb !== 28'h000_0123 || gpio_out !== 28'h1) begin
      bad++; $display("FAIL bp_regs got=%h/%h exp=0000123/0000001", gpio_oeb, gpio_out);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bvalid !== 1'b1 || bid !== 3'd2 || bresp !== 2'b00 || awready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%b/%b exp=1/2/00/0", i, bvalid, bid, bresp, awready);
      end
      step();
    end
    check_b();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=%b/%b exp=0/1", bvalid, awready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    send_aw(3'd4, 32'hD000_0008, 8'd1, 3'd3, 2'b01, 2'b00);
    send_w(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    total++;
    if (la_out !== 64'h5555_5555_5555_5555) begin
      bad++; $display("FAIL mid_beat0 got=%h exp=5555555555555555", la_out);
    end
    wb_rst_i = 1'b1;
    step();
    dropped = sb.pop_back();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b/%b/%b exp=0/0/0", bvalid, awready, wready);
    end
    total++;
    if (gpio_out !== 28'h0 || gpio_oeb !== 28'hFFF_FFFF || la_out !== 64'h0 || bid !== 3'd0) begin
      bad++; $display("FAIL mid_reset_regs got=%h/%h/%h/%0d exp=0/fffffff/0/0", gpio_out, gpio_oeb, la_out, bid);
    end
    wb_rst_i = 1'b0;
    step();
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL mid_reset_awready got=%b exp=1", awready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_noresp id=%0d got=%b exp=0", dropped.id, bvalid); end
      step();
    end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    bready = 1'b0;
    test_reset();
    test_single();
    test_strobes();
    test_burst();
    test_errors();
    test_backpressure();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
